// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the iteration counter for a multiplier of yw bits.
  function automatic int cnt_width(input int yw);
    return $clog2(yw + 1);
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: conditionally adds (or, for the signed MSB, subtracts)
// the extended multiplicand shifted by the current bit index.
module mult_step #(
  parameter int XW = 3,
  parameter int YW = 2,
  parameter int CW = 2
) (
  input  logic [XW+YW-1:0] acc,
  input  logic [XW-1:0]    x,
  input  logic             y_bit,
  input  logic [CW-1:0]    idx,
  input  logic             sgn,
  output logic [XW+YW-1:0] acc_nxt
);

  localparam int PW = XW + YW;

  logic [PW-1:0] x_ext;
  logic [PW-1:0] addend;
  logic          last_bit;

  // The multiplier MSB carries negative weight in two's complement, hence the subtract.
  always_comb begin
    x_ext    = sgn ? {{YW{x[XW-1]}}, x} : {{YW{1'b0}}, x};
    addend   = x_ext << idx;
    last_bit = (idx == CW'(YW - 1));
    if (!y_bit) begin
      acc_nxt = acc;
    end else if (sgn && last_bit) begin
      acc_nxt = acc - addend;
    end else begin
      acc_nxt = acc + addend;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential multiplier: one multiplier bit per cycle, fixed YW-cycle compute,
// valid/ready handshakes on both sides.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int XW        = 3,
  parameter int YW        = 2,
  parameter int SIGNED_EN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XW+YW-1:0] q,
  output logic             busy
);

  localparam int PW = XW + YW;
  localparam int CW = cnt_width(YW);

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            sgn_q, sgn_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   q_q, q_d;

  logic            accept;
  logic            drain;
  logic            calc_last;
  logic [YW-1:0]   y_shift;
  logic [PW-1:0]   step_acc;

  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid_q && out_ready;
  assign calc_last = (cnt_q == CW'(YW - 1));
  assign y_shift   = y_q >> cnt_q;

  mult_step #(
    .XW (XW),
    .YW (YW),
    .CW (CW)
  ) u_step (
    .acc     (acc_q),
    .x       (x_q),
    .y_bit   (y_shift[0]),
    .idx     (cnt_q),
    .sgn     (sgn_q),
    .acc_nxt (step_acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sgn_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      q_q         <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sgn_q       <= sgn_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      q_q         <= q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = accept    ? ST_CALC : ST_IDLE;
      ST_CALC: state_d = calc_last ? ST_DONE : ST_CALC;
      ST_DONE: state_d = drain     ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands are captured only on accept; the counter runs only while calculating.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    sgn_d = sgn_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && accept) begin
      x_d   = x;
      y_d   = y;
      sgn_d = sgn && (SIGNED_EN != 0);
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == ST_CALC) begin
      acc_d = step_acc;
      cnt_d = cnt_q + CW'(1);
    end else begin
      acc_d = acc_q;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    if (state_d == ST_DONE) begin
      q_d = acc_d;
    end else begin
      q_d = '0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign q         = q_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench: default 3x2 unsigned, 8x8 unsigned and 4x4 signed instances.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       a_in_valid = 1'b0, a_in_ready, a_sgn = 1'b0, a_out_valid, a_out_ready = 1'b0, a_busy;
  logic [2:0] a_x = 3'd0;
  logic [1:0] a_y = 2'd0;
  logic [4:0] a_q;

  logic        b_in_valid = 1'b0, b_in_ready, b_sgn = 1'b0, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [7:0]  b_x = 8'd0, b_y = 8'd0;
  logic [15:0] b_q;

  logic       c_in_valid = 1'b0, c_in_ready, c_sgn = 1'b0, c_out_valid, c_out_ready = 1'b0, c_busy;
  logic [3:0] c_x = 4'd0, c_y = 4'd0;
  logic [7:0] c_q;

  seq_multiplier u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y), .sgn(a_sgn), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .q(a_q), .busy(a_busy)
  );

  seq_multiplier #(.XW(8), .YW(8), .SIGNED_EN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .sgn(b_sgn), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .q(b_q), .busy(b_busy)
  );

  seq_multiplier #(.XW(4), .YW(4), .SIGNED_EN(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .x(c_x), .y(c_y), .sgn(c_sgn), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .q(c_q), .busy(c_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_a(input logic [2:0] xv, input logic [1:0] yv, input logic sv, input logic [4:0] eq);
    int lat;
    check("a_in_ready_idle", a_in_ready, 1);
    a_x = xv; a_y = yv; a_sgn = sv; a_in_valid = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      a_in_valid = 1'b0; a_x = ~xv; a_y = ~yv; a_sgn = ~sv;
    end while (!a_out_valid && lat < 20);
    check("a_latency", lat, 3);
    check("a_q", a_q, eq);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    check("a_drain_valid", a_out_valid, 0);
    check("a_drain_q", a_q, 0);
  endtask

  task automatic run_b(input logic [7:0] xv, input logic [7:0] yv, input logic [15:0] eq);
    int lat;
    check("b_in_ready_idle", b_in_ready, 1);
    b_x = xv; b_y = yv; b_in_valid = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      b_in_valid = 1'b0;
      if (lat == 1) check("b_busy_calc", b_busy, 1);
    end while (!b_out_valid && lat < 40);
    check("b_latency", lat, 9);
    check("b_q", b_q, eq);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check("b_drain_valid", b_out_valid, 0);
  endtask

  task automatic run_c(input logic [3:0] xv, input logic [3:0] yv, input logic sv, input logic [7:0] eq);
    int lat;
    c_x = xv; c_y = yv; c_sgn = sv; c_in_valid = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      c_in_valid = 1'b0;
    end while (!c_out_valid && lat < 30);
    check("c_latency", lat, 5);
    check("c_q", c_q, eq);
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
    check("c_drain_valid", c_out_valid, 0);
  endtask

  initial begin
    int  acc_t[3];
    int  n_acc;
    logic ov_seen;

    repeat (3) @(negedge clk);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_q", a_q, 0);
    check("rst_b_in_ready", b_in_ready, 1);
    check("rst_c_out_valid", c_out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exhaustive default configuration, then the documented example with sgn ignored.
    for (int xi = 0; xi < 8; xi++) begin
      for (int yi = 0; yi < 4; yi++) begin
        run_a(3'(xi), 2'(yi), 1'b0, 5'(xi * yi));
      end
    end
    run_a(3'd7, 2'd3, 1'b1, 5'd21);

    // Backpressure: product held while the consumer stalls.
    a_x = 3'd5; a_y = 2'd2; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", a_out_valid, 1);
      check("bp_q", a_q, 10);
      a_x = 3'(i); a_y = 2'(i); a_in_valid = 1'b1;
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    check("bp_valid_last", a_out_valid, 1);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    check("bp_drop_valid", a_out_valid, 0);
    check("bp_drop_q", a_q, 0);
    check("bp_no_accept_on_drain", a_busy, 0);

    // Reset during the third calculation cycle aborts the transaction.
    b_x = 8'd200; b_y = 8'd100; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_in_ready", b_in_ready, 1);
    check("rst_mid_busy", b_busy, 0);
    check("rst_mid_q", b_q, 0);
    ov_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      ov_seen = ov_seen | b_out_valid;
      @(negedge clk);
    end
    check("rst_mid_no_product", ov_seen, 0);
    run_b(8'd3, 8'd4, 16'd12);

    // Back-to-back with both handshakes held high.
    b_x = 8'd255; b_y = 8'd255; b_in_valid = 1'b1; b_out_ready = 1'b1; n_acc = 0;
    for (int cyc = 0; cyc < 60 && n_acc < 3; cyc++) begin
      if (b_in_valid && b_in_ready) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
      if (b_out_valid) check("b2b_q", b_q, 65025);
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    check("b2b_accepts", n_acc, 3);
    if (n_acc == 3) begin
      check("b2b_spacing_1", acc_t[1] - acc_t[0], 10);
      check("b2b_spacing_2", acc_t[2] - acc_t[1], 10);
    end
    for (int i = 0; i < 20 && !b_in_ready; i++) @(negedge clk);
    b_out_ready = 1'b0;
    check("b2b_idle", b_in_ready, 1);

    // Signed mode and the unsigned request on the same instance.
    run_c(4'b1101, 4'b0110, 1'b1, 8'b11101110);
    run_c(4'b1000, 4'b1000, 1'b1, 8'h40);
    run_c(4'b0111, 4'b1111, 1'b1, 8'hF9);
    run_c(4'b1101, 4'b0110, 1'b0, 8'h4E);
    run_c(4'b0000, 4'b1001, 1'b1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
